evt_frame_arbiter: RTL and testbench



---
 rtl/evt_frame_arbiter_if.sv | 28 ++
 rtl/evt_frame_arbiter.sv | 141 ++++++++++++++
 tb/tb_evt_frame_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/evt_frame_arbiter_if.sv
// Event stream bundle between NUM_CH dispatcher channels, the frame arbiter and the DMA.
// slave = arbiter side; master = the channels/DMA driving it.
interface evt_frame_arbiter_if #(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2
);
    logic [NUM_CH-1:0][31:0] evt_data_in;
    logic [NUM_CH-1:0][3:0]  evt_keep_in;
    logic [NUM_CH-1:0]       evt_last_in;
    logic [NUM_CH-1:0]       evt_vld_in;
    logic [NUM_CH-1:0]       evt_rdy_out;
    logic [31:0]             evt_data_out;
    logic [3:0]              evt_keep_out;
    logic                    evt_last_out;
    logic [CH_BITS-1:0]      evt_ch_out;
    logic                    evt_vld_out;
    logic                    evt_rdy_in;

    modport slave (
        input  evt_data_in, evt_keep_in, evt_last_in, evt_vld_in, evt_rdy_in,
        output evt_rdy_out, evt_data_out, evt_keep_out, evt_last_out, evt_ch_out, evt_vld_out
    );

    modport master (
        output evt_data_in, evt_keep_in, evt_last_in, evt_vld_in, evt_rdy_in,
        input  evt_rdy_out, evt_data_out, evt_keep_out, evt_last_out, evt_ch_out, evt_vld_out
    );
endinterface

// File: rtl/evt_frame_arbiter.sv
// Frame-granular round-robin arbiter: NUM_CH event channels onto one registered output,
// with per-frame completion reporting (channel + saturating beat count).
module evt_frame_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int CH_BITS      = 2,
    parameter int EVT_CNT_BITS = 10
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_CH-1:0]       ch_en_in,
    evt_frame_arbiter_if.slave      evt,
    output logic                    frm_done_out,
    output logic [CH_BITS-1:0]      frm_ch_out,
    output logic [EVT_CNT_BITS-1:0] frm_len_out
);
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    localparam logic [CH_BITS:0]   NCH     = (CH_BITS+1)'(NUM_CH);
    localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CH-1);

    state_t                  r_state, w_state_nxt;
    logic [CH_BITS-1:0]      r_grant, r_rr_ptr;
    logic [EVT_CNT_BITS-1:0] r_cnt;
    logic                    r_vld, r_last;
    logic [31:0]             r_data;
    logic [3:0]              r_keep;
    logic [CH_BITS-1:0]      r_ch;
    logic                    r_frm_done;
    logic [CH_BITS-1:0]      r_frm_ch;
    logic [EVT_CNT_BITS-1:0] r_frm_len;

    logic [NUM_CH-1:0]       w_req, w_rdy;
    logic [CH_BITS-1:0]      w_pick, w_grant_inc;
    logic [CH_BITS:0]        w_sum;
    logic                    w_out_free, w_acc_in, w_acc_out, w_in_last;
    logic [EVT_CNT_BITS-1:0] w_cnt_inc;

    assign w_req       = evt.evt_vld_in & ch_en_in;
    assign w_out_free  = !r_vld || evt.evt_rdy_in;
    assign w_acc_out   = r_vld && evt.evt_rdy_in;
    assign w_in_last   = evt.evt_last_in[r_grant];
    assign w_grant_inc = (r_grant == LAST_CH) ? '0 : r_grant + CH_BITS'(1);
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + EVT_CNT_BITS'(1);

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_pick = r_rr_ptr;
        w_sum  = '0;
        for (int k = NUM_CH-1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (CH_BITS+1)'(k);
            if (w_sum >= NCH) w_sum = w_sum - NCH;
            if (w_req[w_sum[CH_BITS-1:0]]) w_pick = w_sum[CH_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|w_req) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_acc_in && w_in_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Only the granted channel ever sees ready; its enable is ignored once granted.
    always_comb begin
        w_rdy    = '0;
        w_acc_in = 1'b0;
        if (r_state == S_BUSY) begin
            w_rdy[r_grant] = w_out_free;
            w_acc_in       = w_out_free && evt.evt_vld_in[r_grant];
        end
    end

    assign evt.evt_rdy_out = w_rdy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (r_state == S_IDLE && |w_req) r_grant <= w_pick;
            if (w_acc_in && w_in_last)       r_rr_ptr <= w_grant_inc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld  <= 1'b0;
            r_last <= 1'b0;
            r_data <= '0;
            r_keep <= '0;
            r_ch   <= '0;
        end else if (w_acc_in) begin
            r_vld  <= 1'b1;
            r_last <= w_in_last;
            r_data <= evt.evt_data_in[r_grant];
            r_keep <= evt.evt_keep_in[r_grant];
            r_ch   <= r_grant;
        end else if (w_out_free) begin
            r_vld  <= 1'b0;
        end
    end

    assign evt.evt_vld_out  = r_vld;
    assign evt.evt_last_out = r_last;
    assign evt.evt_data_out = r_data;
    assign evt.evt_keep_out = r_keep;
    assign evt.evt_ch_out   = r_ch;

    // Frame accounting follows the downstream handshake, not the input side.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_frm_done <= 1'b0;
            r_frm_ch   <= '0;
            r_frm_len  <= '0;
        end else begin
            r_frm_done <= 1'b0;
            if (w_acc_out) begin
                if (r_last) begin
                    r_frm_done <= 1'b1;
                    r_frm_ch   <= r_ch;
                    r_frm_len  <= w_cnt_inc;
                    r_cnt      <= '0;
                end else begin
                    r_cnt      <= w_cnt_inc;
                end
            end
        end
    end

    assign frm_done_out = r_frm_done;
    assign frm_ch_out   = r_frm_ch;
    assign frm_len_out  = r_frm_len;
endmodule

// File: tb/tb_evt_frame_arbiter.sv
// Bench for evt_frame_arbiter: queue-based channel sources and a frame-level round-robin
// model predicting the output beat stream and frame completion reports.
module tb_evt_frame_arbiter;
    localparam int NUM_CH   = 4;
    localparam int CH_BITS  = 2;
    localparam int CNT_BITS = 10;
    localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [CH_BITS-1:0] ch;
        beat_t              b;
    } obeat_t;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic [NUM_CH-1:0]   ch_en_in;
    logic                frm_done_out;
    logic [CH_BITS-1:0]  frm_ch_out;
    logic [CNT_BITS-1:0] frm_len_out;

    evt_frame_arbiter_if #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS)) bus();

    evt_frame_arbiter #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .EVT_CNT_BITS(CNT_BITS)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ch_en_in     (ch_en_in),
        .evt          (bus),
        .frm_done_out (frm_done_out),
        .frm_ch_out   (frm_ch_out),
        .frm_len_out  (frm_len_out)
    );

    always #5 clk = ~clk;

    beat_t  src_q [NUM_CH][$];
    int     src_idx [NUM_CH];
    int     fs_q [NUM_CH][$];
    int     fl_q [NUM_CH][$];
    obeat_t exp_q [$];

    int n_chk = 0;
    int n_fail = 0;
    int rdy_mode = 0;
    int rdy_ph = 0;
    bit mask_chk = 1'b0;
    int mon_cnt = 0;
    bit pend_done = 1'b0;
    logic [CH_BITS-1:0] pend_ch;
    int pend_len;
    bit prev_stall = 1'b0;
    obeat_t prev_beat;
    logic [NUM_CH-1:0] s_rdy, acc_mask;
    logic s_vld;
    logic [CH_BITS-1:0] s_ch;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_CH; i++) begin
            src_q[i].delete();
            fs_q[i].delete();
            fl_q[i].delete();
            src_idx[i] = 0;
        end
        exp_q.delete();
        mon_cnt    = 0;
        pend_done  = 1'b0;
        prev_stall = 1'b0;
        rdy_ph     = 0;
    endtask

    task automatic gen_frame(input int ch, input int len);
        beat_t b;
        fs_q[ch].push_back(src_q[ch].size());
        fl_q[ch].push_back(len);
        for (int j = 0; j < len; j++) begin
            b.data = $urandom;
            b.keep = 4'($urandom_range(1, 15));
            b.last = (j == len - 1);
            src_q[ch].push_back(b);
        end
    endtask

    task automatic expect_frame(input int ch, input int k);
        obeat_t e;
        for (int j = 0; j < fl_q[ch][k]; j++) begin
            e.ch = CH_BITS'(ch);
            e.b  = src_q[ch][fs_q[ch][k] + j];
            exp_q.push_back(e);
        end
    endtask

    // Every enabled channel with frames left is requesting at each arbitration point,
    // so the output order is plain round-robin over frames, starting at channel 0.
    task automatic expect_rr(input logic [NUM_CH-1:0] en);
        int nxt [NUM_CH];
        int ptr, found;
        for (int i = 0; i < NUM_CH; i++) nxt[i] = 0;
        ptr = 0;
        forever begin
            found = -1;
            for (int k = 0; k < NUM_CH; k++) begin
                int c;
                c = (ptr + k) % NUM_CH;
                if (found < 0 && en[c] && nxt[c] < fs_q[c].size()) found = c;
            end
            if (found < 0) break;
            expect_frame(found, nxt[found]);
            nxt[found]++;
            ptr = (found + 1) % NUM_CH;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_CH; i++) begin
            if (src_idx[i] < src_q[i].size()) begin
                bus.evt_vld_in[i]  = 1'b1;
                bus.evt_data_in[i] = src_q[i][src_idx[i]].data;
                bus.evt_keep_in[i] = src_q[i][src_idx[i]].keep;
                bus.evt_last_in[i] = src_q[i][src_idx[i]].last;
            end else begin
                bus.evt_vld_in[i]  = 1'b0;
                bus.evt_data_in[i] = '0;
                bus.evt_keep_in[i] = '0;
                bus.evt_last_in[i] = 1'b0;
            end
        end
        case (rdy_mode)
            0:       bus.evt_rdy_in = 1'b1;
            1:       bus.evt_rdy_in = ($urandom_range(0, 3) != 0);
            default: begin bus.evt_rdy_in = (rdy_ph % 3 == 0); rdy_ph++; end
        endcase
    endtask

    task automatic monitor();
        obeat_t ob, e;
        ob = {bus.evt_ch_out, bus.evt_data_out, bus.evt_keep_out, bus.evt_last_out};
        if (prev_stall) begin
            chk("hold_vld", 64'(s_vld), 64'(1));
            chk("hold_beat", 64'(ob), 64'(prev_beat));
        end
        chk("frm_done", 64'(frm_done_out), 64'(pend_done));
        if (pend_done) begin
            chk("frm_ch", 64'(frm_ch_out), 64'(pend_ch));
            chk("frm_len", 64'(frm_len_out), 64'(pend_len));
        end
        pend_done = 1'b0;
        chk("rdy_onehot", 64'($countones(s_rdy) <= 1), 64'(1));
        if (mask_chk) chk("rdy_masked", 64'(s_rdy & ~ch_en_in), 64'(0));
        if (s_vld && bus.evt_rdy_in) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 64'(s_vld), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("beat", 64'(ob), 64'(e));
                mon_cnt++;
                if (e.b.last) begin
                    pend_done = 1'b1;
                    pend_ch   = e.ch;
                    pend_len  = (mon_cnt > CNT_MAX) ? CNT_MAX : mon_cnt;
                    mon_cnt   = 0;
                end
            end
        end
        prev_stall = s_vld && !bus.evt_rdy_in;
        prev_beat  = ob;
    endtask

    task automatic cycle();
        @(negedge clk);
        s_rdy    = bus.evt_rdy_out;
        s_vld    = bus.evt_vld_out;
        s_ch     = bus.evt_ch_out;
        acc_mask = bus.evt_vld_in & bus.evt_rdy_out;
        if (resetn) monitor();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) if (acc_mask[i]) src_idx[i]++;
        drive();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        clear_model();
        drive();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic run_phase(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend_done) && n < budget) begin
            cycle();
            n++;
        end
        chk("phase_complete", 64'(n < budget), 64'(1));
        repeat (8) cycle();
    endtask

    initial begin
        int n;
        logic [NUM_CH-1:0] en;
        beat_t b;

        // Reset with every input active
        ch_en_in = '1;
        bus.evt_vld_in  = '1;
        bus.evt_data_in = '1;
        bus.evt_keep_in = '1;
        bus.evt_last_in = '1;
        bus.evt_rdy_in  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld",   64'(bus.evt_vld_out),  64'(0));
        chk("rst_last",  64'(bus.evt_last_out), 64'(0));
        chk("rst_ch",    64'(bus.evt_ch_out),   64'(0));
        chk("rst_data",  64'(bus.evt_data_out), 64'(0));
        chk("rst_keep",  64'(bus.evt_keep_out), 64'(0));
        chk("rst_done",  64'(frm_done_out),     64'(0));
        chk("rst_fch",   64'(frm_ch_out),       64'(0));
        chk("rst_flen",  64'(frm_len_out),      64'(0));
        chk("rst_rdy",   64'(bus.evt_rdy_out),  64'(0));

        // Single-beat frame on ch2: arbitration cycle, ready cycle, output cycle
        clear_model();
        b.data = 32'hA5A5A5A5; b.keep = 4'hF; b.last = 1'b1;
        src_q[2].push_back(b);
        fs_q[2].push_back(0);
        fl_q[2].push_back(1);
        expect_frame(2, 0);
        drive();
        resetn = 1'b1;
        cycle(); chk("t1_idle_rdy",  64'(s_rdy), 64'(0));
        cycle(); chk("t1_grant_rdy", 64'(s_rdy), 64'(4'b0100));
        cycle(); chk("t1_out_vld",   64'(s_vld), 64'(1));
                 chk("t1_out_ch",    64'(s_ch),  64'(2));
        run_phase(20);

        // All channels, 3-beat frames, downstream always ready
        do_reset();
        for (int c = 0; c < NUM_CH; c++) repeat (2) gen_frame(c, 3);
        expect_rr('1);
        drive();
        run_phase(200);

        // ch1 5-beat frame under 1,0,0 downstream stalls
        do_reset();
        rdy_mode = 2;
        gen_frame(1, 5);
        expect_rr('1);
        drive();
        run_phase(100);
        rdy_mode = 0;

        // ch2 disabled while everyone requests
        do_reset();
        ch_en_in = 4'b1011;
        mask_chk = 1'b1;
        for (int c = 0; c < NUM_CH; c++) repeat (2) gen_frame(c, 2);
        expect_rr(4'b1011);
        drive();
        run_phase(200);
        mask_chk = 1'b0;

        // ch0 disabled mid-frame: frame completes, later ch0 frame never granted
        do_reset();
        ch_en_in = '1;
        gen_frame(0, 4); gen_frame(0, 2);
        gen_frame(1, 3); gen_frame(1, 3);
        expect_frame(0, 0); expect_frame(1, 0); expect_frame(1, 1);
        drive();
        n = 0;
        while (mon_cnt == 0 && n < 20) begin cycle(); n++; end
        chk("dis_first_beat", 64'(n < 20), 64'(1));
        ch_en_in = 4'b1110;
        run_phase(200);
        ch_en_in = '1;

        // Beat counter saturation
        do_reset();
        gen_frame(3, 1100);
        expect_frame(3, 0);
        drive();
        run_phase(1500);

        // Reset during third beat of a ch0 frame; rr pointer must restart at 0
        do_reset();
        gen_frame(2, 1);
        expect_frame(2, 0);
        drive();
        run_phase(20);
        gen_frame(0, 5);
        expect_frame(0, 0);
        drive();
        n = 0;
        while (mon_cnt < 2 && n < 30) begin cycle(); n++; end
        chk("mrst_two_beats", 64'(n < 30), 64'(1));
        resetn = 1'b0;
        #1;
        chk("mrst_vld",  64'(bus.evt_vld_out), 64'(0));
        chk("mrst_done", 64'(frm_done_out),    64'(0));
        clear_model();
        drive();
        cycle();
        cycle();
        chk("mrst_done_hold", 64'(frm_done_out), 64'(0));
        resetn = 1'b1;
        gen_frame(3, 2);
        gen_frame(1, 2);
        expect_frame(1, 0);
        expect_frame(3, 0);
        drive();
        run_phase(100);

        // Randomized phases: random enable mask, frame mix and downstream stalls
        for (int r = 0; r < 6; r++) begin
            do_reset();
            en = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            ch_en_in = en;
            mask_chk = 1'b1;
            rdy_mode = $urandom_range(0, 2);
            for (int c = 0; c < NUM_CH; c++) begin
                int nf;
                nf = $urandom_range(1, 3);
                for (int f = 0; f < nf; f++) gen_frame(c, $urandom_range(1, 6));
            end
            expect_rr(en);
            drive();
            run_phase(1500);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
